// File: rtl/jt49_pkg.sv
// Shared constants and types for the JT49 envelope generator.
// The divider limit helper is shared with the tone and noise dividers.
package jt49_pkg;

   localparam int PERW  = 16;
   localparam int STEPW = 5;

   localparam int SH_CONT = 3;
   localparam int SH_ATT  = 2;
   localparam int SH_ALT  = 1;
   localparam int SH_HOLD = 0;

   localparam logic [STEPW-1:0] ENV_MAX = 5'd31;

   typedef enum logic {
      ENV_RUN  = 1'b0,
      ENV_HOLD = 1'b1
   } env_state_e;

   // A zero period behaves as one, so the terminal count is period-1 floored at 0.
   function automatic logic [PERW-1:0] div_limit(input logic [PERW-1:0] p);
      logic [PERW-1:0] lim;
      if (p == 16'd0) begin
         lim = 16'd0;
      end else begin
         lim = p - 16'd1;
      end
      return lim;
   endfunction

endpackage

// File: rtl/jt49_env_div.sv
// Envelope period divider: counts cen256 pulses and emits a one-cycle step
// pulse each time the count reaches the period terminal value.
module jt49_env_div
   import jt49_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cen256,
   input  logic            clr,
   input  logic            freeze,
   input  logic [PERW-1:0] period,
   output logic            step
);

   logic [PERW-1:0] cnt_q;
   logic [PERW-1:0] cnt_d;
   logic [PERW-1:0] lim_s;

   // Next count and step pulse; ">=" lets a lowered period take effect at once.
   always_comb begin
      lim_s = div_limit(period);
      cnt_d = cnt_q;
      step  = 1'b0;
      if (clr) begin
         cnt_d = 16'd0;
      end else if (cen256 && !freeze) begin
         if (cnt_q >= lim_s) begin
            cnt_d = 16'd0;
            step  = 1'b1;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Period counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/jt49_env.sv
// JT49 envelope generator: 32-step level sequencer following the eight
// AY-3-8910/YM2149 envelope shapes, with registered level and hold flag.
module jt49_env
   import jt49_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cen256,
   input  logic [PERW-1:0]  period,
   input  logic [3:0]       shape,
   input  logic             restart,
   output logic [STEPW-1:0] env,
   output logic             holding
);

   env_state_e       state_q, state_d;
   logic [STEPW-1:0] step_q, step_d;
   logic [STEPW-1:0] env_q, env_d;
   logic             inv_q, inv_d;
   logic             holding_q, holding_d;
   logic             div_step_s;
   logic             freeze_s;

   assign freeze_s = (state_q == ENV_HOLD);

   jt49_env_div u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .cen256 (cen256),
      .clr    (restart),
      .freeze (freeze_s),
      .period (period),
      .step   (div_step_s)
   );

   // Shape sequencing: restart wins over any coincident step.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      inv_d     = inv_q;
      env_d     = env_q;
      holding_d = holding_q;
      if (restart) begin
         state_d   = ENV_RUN;
         step_d    = 5'd0;
         inv_d     = ~shape[SH_ATT];
         env_d     = shape[SH_ATT] ? 5'd0 : ENV_MAX;
         holding_d = 1'b0;
      end else if (div_step_s) begin
         if (step_q == ENV_MAX) begin
            if (!shape[SH_CONT]) begin
               state_d   = ENV_HOLD;
               env_d     = 5'd0;
               holding_d = 1'b1;
            end else if (shape[SH_HOLD]) begin
               state_d   = ENV_HOLD;
               env_d     = (shape[SH_ATT] ^ shape[SH_ALT]) ? ENV_MAX : 5'd0;
               holding_d = 1'b1;
            end else if (shape[SH_ALT]) begin
               step_d = 5'd0;
               inv_d  = ~inv_q;
               env_d  = {STEPW{~inv_q}};
            end else begin
               step_d = 5'd0;
               env_d  = {STEPW{inv_q}};
            end
         end else begin
            step_d = step_q + 5'd1;
            env_d  = (step_q + 5'd1) ^ {STEPW{inv_q}};
         end
      end else begin
         env_d = env_q;
      end
   end

   // Sequencer state and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ENV_RUN;
         step_q    <= 5'd0;
         inv_q     <= 1'b0;
         env_q     <= 5'd0;
         holding_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         inv_q     <= inv_d;
         env_q     <= env_d;
         holding_q <= holding_d;
      end
   end

   assign env     = env_q;
   assign holding = holding_q;

endmodule

// File: tb/tb_jt49_env.sv
// Directed self-checking bench for jt49_env; expected levels are derived
// by hand from the envelope shape rules.
module tb_jt49_env;

   logic        clk;
   logic        rst_n;
   logic        cen256;
   logic [15:0] period;
   logic [3:0]  shape;
   logic        restart;
   logic [4:0]  env;
   logic        holding;

   int n_cmp;
   int n_err;

   jt49_env dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cen256  (cen256),
      .period  (period),
      .shape   (shape),
      .restart (restart),
      .env     (env),
      .holding (holding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // one clock with the given cen256/restart levels; returns 1 ns after the edge
   task automatic cyc(input logic c, input logic r);
      cen256  = c;
      restart = r;
      @(posedge clk);
      #1;
      cen256  = 1'b0;
      restart = 1'b0;
   endtask

   task automatic cen_pulse();
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
   endtask

   task automatic do_restart();
      cyc(1'b0, 1'b1);
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      cen256  = 1'b0;
      restart = 1'b0;
      period  = 16'd1;
      shape   = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_env", int'(env), 0);
      chk("reset_holding", int'(holding), 0);
      rst_n = 1'b1;
      cyc(1'b0, 1'b0);

      // attack then hold at 31
      shape  = 4'b1101;
      period = 16'd1;
      do_restart();
      chk("s1101_restart_env", int'(env), 0);
      chk("s1101_restart_hold", int'(holding), 0);
      for (int k = 1; k <= 31; k++) begin
         cen_pulse();
         chk("s1101_attack", int'(env), k);
      end
      chk("s1101_pre_end_hold", int'(holding), 0);
      for (int k = 0; k < 101; k++) begin
         cen_pulse();
         chk("s1101_hold_env", int'(env), 31);
         chk("s1101_hold_flag", int'(holding), 1);
      end

      // triangle starting with decay, two cen256 per step
      shape  = 4'b1010;
      period = 16'd2;
      do_restart();
      chk("s1010_restart_env", int'(env), 31);
      for (int k = 1; k <= 260; k++) begin
         int s;
         int p;
         cen_pulse();
         s = k / 2;
         p = s % 64;
         chk("s1010_tri", int'(env), (p < 32) ? (31 - p) : (p - 32));
      end
      chk("s1010_no_hold", int'(holding), 0);

      // single decay then hold at 0
      shape  = 4'b0000;
      period = 16'd1;
      do_restart();
      chk("s0000_restart_env", int'(env), 31);
      for (int k = 1; k <= 31; k++) begin
         cen_pulse();
         chk("s0000_decay", int'(env), 31 - k);
      end
      chk("s0000_pre_end_hold", int'(holding), 0);
      for (int k = 0; k < 10; k++) begin
         cen_pulse();
         chk("s0000_hold_env", int'(env), 0);
         chk("s0000_hold_flag", int'(holding), 1);
      end

      // single attack then drop to 0 and hold; restart leaves HOLD
      shape = 4'b0111;
      do_restart();
      chk("s0111_restart_env", int'(env), 0);
      chk("s0111_restart_hold", int'(holding), 0);
      for (int k = 1; k <= 31; k++) begin
         cen_pulse();
         chk("s0111_attack", int'(env), k);
      end
      for (int k = 0; k < 5; k++) begin
         cen_pulse();
         chk("s0111_hold_env", int'(env), 0);
         chk("s0111_hold_flag", int'(holding), 1);
      end

      // period 0 and period 1 both step on every cen256 (sawtooth down)
      shape  = 4'b1000;
      period = 16'd0;
      do_restart();
      chk("p0_restart_env", int'(env), 31);
      for (int k = 1; k <= 40; k++) begin
         cen_pulse();
         chk("p0_saw", int'(env), 31 - (k % 32));
      end
      period = 16'd1;
      do_restart();
      chk("p1_restart_env", int'(env), 31);
      for (int k = 1; k <= 40; k++) begin
         cen_pulse();
         chk("p1_saw", int'(env), 31 - (k % 32));
      end

      // lowering the period mid-count steps on the next cen256
      period = 16'd1000;
      do_restart();
      for (int k = 0; k < 500; k++) begin
         cen_pulse();
      end
      chk("p1000_env", int'(env), 31);
      chk("p1000_cnt", int'(dut.u_div.cnt_q), 500);
      period = 16'd100;
      cen_pulse();
      chk("p100_first_env", int'(env), 30);
      chk("p100_cnt_zero", int'(dut.u_div.cnt_q), 0);
      for (int k = 0; k < 99; k++) begin
         cen_pulse();
      end
      chk("p100_wait_env", int'(env), 30);
      cen_pulse();
      chk("p100_next_env", int'(env), 29);

      // restart coincident with a stepping cen256
      shape  = 4'b1110;
      period = 16'd1;
      do_restart();
      chk("s1110_restart_env", int'(env), 0);
      for (int k = 1; k <= 17; k++) begin
         cen_pulse();
      end
      chk("s1110_step17", int'(env), 17);
      cyc(1'b1, 1'b1);
      chk("coinc_env", int'(env), 0);
      chk("coinc_step", int'(dut.step_q), 0);
      cyc(1'b0, 1'b0);
      chk("coinc_settle", int'(env), 0);
      cen_pulse();
      chk("coinc_next", int'(env), 1);

      // asynchronous reset mid-decay
      shape  = 4'b0000;
      period = 16'd3;
      do_restart();
      for (int k = 0; k < 57; k++) begin
         cen_pulse();
      end
      chk("rst_pre_env", int'(env), 12);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_env", int'(env), 0);
      chk("rst_async_hold", int'(holding), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_held_env", int'(env), 0);
      cen_pulse();
      cen_pulse();
      chk("rst_no_step", int'(env), 0);
      cen_pulse();
      chk("rst_first_step", int'(env), 1);
      chk("rst_first_hold", int'(holding), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
